// File: rtl/vcr_ovc_state_track.sv
// Per-output-VC allocation state, owner capture and downstream credit tracking for one output port.
// Optional build macro VCR_OVC_ATOMIC_ALLOC_EN holds a released VC in DRAIN until every credit is back.
module vcr_ovc_state_track #(
  parameter int num_vcs     = 4,
  parameter int num_ports   = 5,
  parameter int buffer_size = 8,
  localparam int cred_width = $clog2(buffer_size + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [num_vcs-1:0]           gnt_ovc,
  input  logic [num_vcs*num_ports-1:0] sel_ovc_ip,
  input  logic [num_vcs*num_vcs-1:0]   sel_ovc_ivc,
  input  logic                         flit_valid,
  input  logic [num_vcs-1:0]           flit_sel_ovc,
  input  logic                         flit_tail,
  input  logic                         cred_valid,
  input  logic [num_vcs-1:0]           cred_sel_ovc,
  output logic [num_vcs-1:0]           elig_ovc,
  output logic [num_vcs-1:0]           full_ovc,
  output logic [num_vcs-1:0]           empty_ovc,
  output logic [num_vcs*num_ports-1:0] owner_ovc_ip,
  output logic [num_vcs*num_vcs-1:0]   owner_ovc_ivc,
  output logic [num_vcs-1:0]           error_ovc,
  output logic [2*num_vcs-1:0]         state_dbg
);

  // Handshake: a grant, flit or credit is taken on the rising edge it is presented;
  // there is no back-pressure, so every presented event must be consumed or flagged.
  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_active = 2'd1,
    st_drain  = 2'd2
  } ovc_state_e;

  localparam logic [cred_width-1:0] cred_max = cred_width'(buffer_size);
  localparam logic [cred_width-1:0] cred_one = cred_width'(1);

  ovc_state_e            state_q  [num_vcs];
  logic [cred_width-1:0] cred_q   [num_vcs];
  logic [cred_width-1:0] cred_nxt [num_vcs];
  logic [num_vcs-1:0]    flit_hit;
  logic [num_vcs-1:0]    cred_hit;
  logic [num_vcs-1:0]    err_set;

  assign flit_hit = flit_sel_ovc & {num_vcs{flit_valid}};
  assign cred_hit = cred_sel_ovc & {num_vcs{cred_valid}};

  // A flit and a credit on the same VC cancel, so neither bound can be violated.
  always_comb begin
    for (int v = 0; v < num_vcs; v++) begin
      cred_nxt[v] = cred_q[v];
      err_set[v]  = 1'b0;
      if (gnt_ovc[v] && (state_q[v] != st_idle))
        err_set[v] = 1'b1;
      if (flit_hit[v] && (state_q[v] != st_active))
        err_set[v] = 1'b1;
      if (flit_hit[v] && !cred_hit[v]) begin
        if (cred_q[v] == '0) err_set[v] = 1'b1;
        else                 cred_nxt[v] = cred_q[v] - cred_one;
      end else if (cred_hit[v] && !flit_hit[v]) begin
        if (cred_q[v] == cred_max) err_set[v] = 1'b1;
        else                       cred_nxt[v] = cred_q[v] + cred_one;
      end
    end
  end

  always_comb begin
    for (int v = 0; v < num_vcs; v++) begin
      elig_ovc[v]          = (state_q[v] == st_idle);
      full_ovc[v]          = (cred_q[v] == '0);
      empty_ovc[v]         = (cred_q[v] == cred_max);
      state_dbg[2*v +: 2]  = state_q[v];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < num_vcs; v++) begin
        state_q[v] <= st_idle;
        cred_q[v]  <= cred_max;
      end
      owner_ovc_ip  <= '0;
      owner_ovc_ivc <= '0;
      error_ovc     <= '0;
    end else begin
      error_ovc <= error_ovc | err_set;
      for (int v = 0; v < num_vcs; v++) begin
        cred_q[v] <= cred_nxt[v];
        case (state_q[v])
          st_idle: begin
            if (gnt_ovc[v]) begin
              state_q[v]                              <= st_active;
              owner_ovc_ip[v*num_ports +: num_ports]  <= sel_ovc_ip[v*num_ports +: num_ports];
              owner_ovc_ivc[v*num_vcs +: num_vcs]     <= sel_ovc_ivc[v*num_vcs +: num_vcs];
            end
          end
          st_active: begin
            if (flit_hit[v] && flit_tail) begin
`ifdef VCR_OVC_ATOMIC_ALLOC_EN
              state_q[v] <= st_drain;
`else
              state_q[v] <= st_idle;
`endif
            end
          end
          // Release once the count about to be registered shows every downstream slot free.
          st_drain: begin
            if (cred_nxt[v] == cred_max) state_q[v] <= st_idle;
          end
          default: state_q[v] <= st_idle;
        endcase
      end
    end
  end

endmodule
